// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream memory loader: FSM state encoding and byte width.
package mem_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_loader.sv
// Assembles a high-byte-first byte stream into 16-bit words and writes them to consecutive
// addresses from 0, accumulating a wrap-around checksum; every output is registered.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int WORDS      = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [WORDS-1:0]      count_i,
  input  logic [BYTE_W-1:0]     byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_write_en_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  state_t           state;
  logic [WORDS-1:0] remaining;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state           <= ST_IDLE;
      byte_ready_o    <= 1'b0;
      mem_write_en_no <= 1'b1;
      done_o          <= 1'b0;
      busy_o          <= 1'b0;
      mem_addr_o      <= '0;
      mem_data_o      <= '0;
      checksum_o      <= '0;
      remaining       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort_i outranks start_i even though it has nothing to cancel here
          if (start_i && !abort_i) begin
            state        <= ST_HIGH;
            mem_addr_o   <= '0;
            checksum_o   <= '0;
            remaining    <= count_i;
            byte_ready_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (abort_i) begin
            state        <= ST_IDLE;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
          end else if (byte_valid_i) begin
            mem_data_o[DATA_WIDTH-1 -: BYTE_W] <= byte_i;
            state <= ST_LOW;
          end
        end

        ST_LOW: begin
          if (abort_i) begin
            state        <= ST_IDLE;
            byte_ready_o <= 1'b0;
            busy_o       <= 1'b0;
          end else if (byte_valid_i) begin
            mem_data_o[BYTE_W-1:0] <= byte_i;
            state           <= ST_WRITE;
            byte_ready_o    <= 1'b0;
            mem_write_en_no <= 1'b0;
          end
        end

        ST_WRITE: begin
          // The write strobe spans this whole cycle, so an abort here still commits the word.
          mem_write_en_no <= 1'b1;
          checksum_o      <= checksum_o + mem_data_o;
          if (abort_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (remaining == '0) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            state        <= ST_HIGH;
            mem_addr_o   <= mem_addr_o + WORDS'(1);
            remaining    <= remaining - WORDS'(1);
            byte_ready_o <= 1'b1;
          end
        end

        ST_DONE: begin
          done_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state           <= ST_IDLE;
          byte_ready_o    <= 1'b0;
          mem_write_en_no <= 1'b1;
          done_o          <= 1'b0;
          busy_o          <= 1'b0;
        end
      endcase
    end
  end

endmodule
